// File: rtl/fft_peak_analyzer.sv
// Spectral peak finder: captures one FFT frame, scans its bins one per cycle for the
// largest re^2+im^2, then reports the bin index, its power and a threshold verdict.
module fft_peak_analyzer #(
  parameter int NBINS         = 16,
  parameter int DW            = 16,
  parameter int HALF_SPECTRUM = 0,
  parameter int IDXW          = $clog2(NBINS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fft_valid,
  input  logic [NBINS*2*DW-1:0] fft_d,
  input  logic [2*DW:0]         threshold,
  output logic                  busy,
  output logic                  done,
  output logic [IDXW-1:0]       freq,
  output logic [2*DW:0]         peak_mag,
  output logic                  no_peak,
  output logic                  overrun
);

  localparam int MW = 2*DW + 1;
  localparam logic [IDXW-1:0] LAST = IDXW'((HALF_SPECTRUM != 0) ? NBINS/2 : NBINS-1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          r_state;
  logic [IDXW-1:0] r_k;
  logic [MW-1:0]   r_best_mag;
  logic [IDXW-1:0] r_best_idx;
  logic [MW-1:0]   r_thr;
  logic [DW-1:0]   r_re [NBINS];
  logic [DW-1:0]   r_im [NBINS];

  logic [DW-1:0]   w_re_in [NBINS];
  logic [DW-1:0]   w_im_in [NBINS];
  logic [MW-1:0]   w_re_x;
  logic [MW-1:0]   w_im_x;
  logic [MW-1:0]   w_mag;
  logic            w_take;
  logic [MW-1:0]   w_fin_mag;
  logic [IDXW-1:0] w_fin_idx;
  logic            w_capture;

  for (genvar gi = 0; gi < NBINS; gi++) begin : g_unpack
    assign w_re_in[gi] = fft_d[(2*gi+1)*DW +: DW];
    assign w_im_in[gi] = fft_d[2*gi*DW +: DW];
  end

  // Sign-extend to the result width; the low MW bits of the product are exact.
  assign w_re_x    = {{(DW+1){r_re[r_k][DW-1]}}, r_re[r_k]};
  assign w_im_x    = {{(DW+1){r_im[r_k][DW-1]}}, r_im[r_k]};
  assign w_mag     = w_re_x * w_re_x + w_im_x * w_im_x;
  assign w_take    = w_mag > r_best_mag;
  assign w_fin_mag = w_take ? w_mag : r_best_mag;
  assign w_fin_idx = w_take ? r_k : r_best_idx;
  assign w_capture = fft_valid && (r_state != SCAN);

  always_ff @(posedge clk) begin
    if (!rst && w_capture) begin
      for (int i = 0; i < NBINS; i++) begin
        r_re[i] <= w_re_in[i];
        r_im[i] <= w_im_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_best_mag <= '0;
      r_best_idx <= '0;
      r_thr      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      freq       <= '0;
      peak_mag   <= '0;
      no_peak    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      case (r_state)
        SCAN: begin
          overrun    <= fft_valid;
          r_best_mag <= w_fin_mag;
          r_best_idx <= w_fin_idx;
          r_k        <= r_k + 1'b1;
          if (r_k == LAST) begin
            r_state  <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            peak_mag <= w_fin_mag;
            no_peak  <= (w_fin_mag < r_thr);
            freq     <= (w_fin_mag < r_thr) ? '0 : w_fin_idx;
          end
        end
        default: begin
          // IDLE and DONE both accept a new frame.
          if (fft_valid) begin
            r_state    <= SCAN;
            r_thr      <= threshold;
            r_k        <= '0;
            r_best_mag <= '0;
            r_best_idx <= '0;
            busy       <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_analyzer.sv
// Scoreboard bench for fft_peak_analyzer: default instance plus a half-spectrum instance.
module tb_fft_peak_analyzer;
  localparam int NB = 16;
  localparam int DW = 16;
  localparam int W  = NB*2*DW;
  localparam int MW = 2*DW + 1;

  typedef struct packed {
    logic [3:0]    freq;
    logic [MW-1:0] mag;
    logic          np;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          fv = 1'b0, fv_h = 1'b0;
  logic [W-1:0]  fd = '0, fd_h = '0;
  logic [MW-1:0] thr = '0, thr_h = '0;
  logic          busy, done, np, ovr;
  logic [3:0]    freq;
  logic [MW-1:0] mag;
  logic          busy_h, done_h, np_h, ovr_h;
  logic [3:0]    freq_h;
  logic [MW-1:0] mag_h;

  exp_t sb[$];
  exp_t sb_h[$];
  int   sb_t[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [15:0] b_re [NB];
  logic [15:0] b_im [NB];

  always @(posedge clk) cyc <= cyc + 1;

  fft_peak_analyzer dut (
    .clk(clk), .rst(rst), .fft_valid(fv), .fft_d(fd), .threshold(thr),
    .busy(busy), .done(done), .freq(freq), .peak_mag(mag), .no_peak(np), .overrun(ovr)
  );

  fft_peak_analyzer #(.HALF_SPECTRUM(1)) dut_h (
    .clk(clk), .rst(rst), .fft_valid(fv_h), .fft_d(fd_h), .threshold(thr_h),
    .busy(busy_h), .done(done_h), .freq(freq_h), .peak_mag(mag_h), .no_peak(np_h),
    .overrun(ovr_h)
  );

  task automatic clear_bins();
    for (int k = 0; k < NB; k++) begin
      b_re[k] = '0;
      b_im[k] = '0;
    end
  endtask

  function automatic logic [W-1:0] pack_bins();
    logic [W-1:0] p;
    p = '0;
    for (int k = 0; k < NB; k++) p[k*2*DW +: 2*DW] = {b_re[k], b_im[k]};
    return p;
  endfunction

  function automatic exp_t model(input int last, input logic [MW-1:0] t);
    exp_t   e;
    longint best, p, re, im;
    int     idx;
    best = 0;
    idx  = 0;
    for (int k = 0; k <= last; k++) begin
      re = longint'($signed(b_re[k]));
      im = longint'($signed(b_im[k]));
      p  = re*re + im*im;
      if (p > best) begin
        best = p;
        idx  = k;
      end
    end
    e.mag  = best[MW-1:0];
    e.np   = (best < longint'(t));
    e.freq = e.np ? 4'd0 : idx[3:0];
    return e;
  endfunction

  // Drives one frame at a negedge; returns at the following negedge.
  task automatic send(input logic [MW-1:0] t, input exp_t e, input bit push);
    fv  = 1'b1;
    fd  = pack_bins();
    thr = t;
    if (push) begin
      sb.push_back(e);
      sb_t.push_back(cyc);
    end
    @(negedge clk);
    fv = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_capture: got %b expected 1", busy);
    end
  endtask

  task automatic wait_result(input string name, input int lat);
    exp_t e;
    int   n, t0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s timeout: done not seen within 40 cycles", name);
      if (sb.size() > 0) begin
        void'(sb.pop_front());
        void'(sb_t.pop_front());
      end
      return;
    end
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: done with empty scoreboard", name);
      return;
    end
    e  = sb.pop_front();
    t0 = sb_t.pop_front();
    vectors++;
    if (freq !== e.freq) begin
      miscompares++;
      $display("FAIL %s freq: got %0d expected %0d", name, freq, e.freq);
    end
    vectors++;
    if (mag !== e.mag) begin
      miscompares++;
      $display("FAIL %s peak_mag: got %h expected %h", name, mag, e.mag);
    end
    vectors++;
    if (np !== e.np) begin
      miscompares++;
      $display("FAIL %s no_peak: got %b expected %b", name, np, e.np);
    end
    vectors++;
    if ((cyc - t0) !== lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d expected %0d", name, cyc - t0, lat);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_in_done: got %b expected 0", name, busy);
    end
    $display("result %s: freq=%0d peak_mag=%h no_peak=%b latency=%0d", name, freq, mag, np, cyc - t0);
  endtask

  task automatic no_done_window(input string name);
    int seen;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL %s: got %0d done pulses expected 0", name, seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 12;
    if (busy !== 1'b0)   begin miscompares++; $display("FAIL reset busy: got %b expected 0", busy); end
    if (done !== 1'b0)   begin miscompares++; $display("FAIL reset done: got %b expected 0", done); end
    if (freq !== 4'd0)   begin miscompares++; $display("FAIL reset freq: got %0d expected 0", freq); end
    if (mag !== '0)      begin miscompares++; $display("FAIL reset peak_mag: got %h expected 0", mag); end
    if (np !== 1'b0)     begin miscompares++; $display("FAIL reset no_peak: got %b expected 0", np); end
    if (ovr !== 1'b0)    begin miscompares++; $display("FAIL reset overrun: got %b expected 0", ovr); end
    if (busy_h !== 1'b0) begin miscompares++; $display("FAIL reset_h busy: got %b expected 0", busy_h); end
    if (done_h !== 1'b0) begin miscompares++; $display("FAIL reset_h done: got %b expected 0", done_h); end
    if (freq_h !== 4'd0) begin miscompares++; $display("FAIL reset_h freq: got %0d expected 0", freq_h); end
    if (mag_h !== '0)    begin miscompares++; $display("FAIL reset_h peak_mag: got %h expected 0", mag_h); end
    if (np_h !== 1'b0)   begin miscompares++; $display("FAIL reset_h no_peak: got %b expected 0", np_h); end
    if (ovr_h !== 1'b0)  begin miscompares++; $display("FAIL reset_h overrun: got %b expected 0", ovr_h); end
    $display("reset: outputs sampled");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    clear_bins();
    b_re[1]  = 16'h0400;
    b_re[15] = 16'h0400;
    send('0, {4'd1, 33'h100000, 1'b0}, 1'b1);
    wait_result("tie", 17);
  endtask

  task automatic test_half();
    exp_t e;
    int   n, t0;
    clear_bins();
    b_re[15] = 16'h7FFF;
    b_im[3]  = 16'h0100;
    fv_h  = 1'b1;
    fd_h  = pack_bins();
    thr_h = '0;
    sb_h.push_back({4'd3, 33'h10000, 1'b0});
    t0 = cyc;
    @(negedge clk);
    fv_h = 1'b0;
    n = 0;
    while (done_h !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = sb_h.pop_front();
    vectors += 4;
    if (done_h !== 1'b1)   begin miscompares++; $display("FAIL half timeout: done not seen"); end
    if (freq_h !== e.freq) begin miscompares++; $display("FAIL half freq: got %0d expected %0d", freq_h, e.freq); end
    if (mag_h !== e.mag)   begin miscompares++; $display("FAIL half peak_mag: got %h expected %h", mag_h, e.mag); end
    if ((cyc - t0) !== 10) begin miscompares++; $display("FAIL half latency: got %0d expected 10", cyc - t0); end
    $display("result half: freq=%0d peak_mag=%h latency=%0d", freq_h, mag_h, cyc - t0);
  endtask

  task automatic test_threshold();
    clear_bins();
    for (int k = 0; k < NB; k++) begin
      b_re[k] = 16'h0100;
      b_im[k] = 16'h0100;
    end
    send(33'h20000, {4'd0, 33'h20000, 1'b0}, 1'b1);
    wait_result("thr_equal", 17);
    @(negedge clk);
    send(33'h20001, {4'd0, 33'h20000, 1'b1}, 1'b1);
    wait_result("thr_above", 17);
    @(negedge clk);
  endtask

  task automatic test_sign();
    clear_bins();
    for (int k = 0; k < NB; k++) b_re[k] = 16'h7FFF;
    b_re[7] = 16'h8000;
    b_im[7] = 16'h8000;
    send('0, {4'd7, 33'h80000000, 1'b0}, 1'b1);
    wait_result("sign_width", 17);
    @(negedge clk);
  endtask

  task automatic test_overrun();
    clear_bins();
    b_re[1]  = 16'h0400;
    b_re[15] = 16'h0400;
    send('0, {4'd1, 33'h100000, 1'b0}, 1'b1);
    repeat (4) @(negedge clk);
    clear_bins();
    b_re[2] = 16'h7FFF;
    fv = 1'b1;
    fd = pack_bins();
    @(negedge clk);
    fv = 1'b0;
    vectors++;
    if (ovr !== 1'b1) begin miscompares++; $display("FAIL overrun pulse: got %b expected 1", ovr); end
    @(negedge clk);
    vectors++;
    if (ovr !== 1'b0) begin miscompares++; $display("FAIL overrun width: got %b expected 0", ovr); end
    wait_result("overrun_first", 17);
    no_done_window("overrun_no_second_done");
  endtask

  task automatic test_back_to_back();
    clear_bins();
    b_re[5] = 16'h0200;
    send('0, {4'd5, 33'h40000, 1'b0}, 1'b1);
    wait_result("b2b_first", 17);
    clear_bins();
    b_im[9] = 16'h0300;
    send('0, {4'd9, 33'h90000, 1'b0}, 1'b1);
    vectors += 2;
    if (ovr !== 1'b0)  begin miscompares++; $display("FAIL b2b overrun: got %b expected 0", ovr); end
    if (freq !== 4'd5) begin miscompares++; $display("FAIL b2b hold freq: got %0d expected 5", freq); end
    wait_result("b2b_second", 17);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    clear_bins();
    b_re[4] = 16'h1000;
    send('0, '0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    fv  = 1'b1;
    @(negedge clk);
    vectors += 5;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst busy: got %b expected 0", busy); end
    if (freq !== 4'd0) begin miscompares++; $display("FAIL midrst freq: got %0d expected 0", freq); end
    if (mag !== '0)    begin miscompares++; $display("FAIL midrst peak_mag: got %h expected 0", mag); end
    if (np !== 1'b0)   begin miscompares++; $display("FAIL midrst no_peak: got %b expected 0", np); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL midrst done: got %b expected 0", done); end
    rst = 1'b0;
    fv  = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst ignored_valid: got busy %b expected 0", busy); end
    no_done_window("midrst_no_done");
    clear_bins();
    b_re[12] = 16'hFF00;
    b_im[12] = 16'h0010;
    send('0, {4'd12, 33'h10100, 1'b0}, 1'b1);
    wait_result("after_reset", 17);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [MW-1:0] t;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NB; k++) begin
        b_re[k] = 16'($urandom);
        b_im[k] = 16'($urandom);
      end
      t = (i % 2 == 1) ? MW'($urandom) : '0;
      send(t, model(NB-1, t), 1'b1);
      wait_result("random", 17);
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_tie();
    test_half();
    test_threshold();
    test_sign();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_peak_analyzer.md
# fft_peak_analyzer

Parametrised spectral-peak analysis stage for the frequency analysis system. It sits downstream of the FFT. On each FFT frame it captures all complex bins in one cycle. It then scans them sequentially, one bin per cycle, computing power as re²+im². It reports the index of the strongest bin, that bin's power, and a threshold-qualified result. This generalises the fixed 16-bin, full-spectrum `freq` analysis to any bin count, sample width and spectrum mode, and adds a threshold check and overrun detection.

## Interface
- NBINS, 16, number of FFT bins; power of two, ≥ 4.
- DW, 16, width of each real or imaginary part (signed two's complement).
- HALF_SPECTRUM, 0, 0: scan bins 0..NBINS-1; 1: scan bins 0..NBINS/2 only.
- IDXW, $clog2(NBINS), bin index width (derived; do not override).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fft_valid  in  1  one-cycle frame strobe; fft_d is valid in the same cycle.
- fft_d  in  NBINS*2*DW  bin k occupies [(k+1)*2*DW-1 : k*2*DW]; real part in the upper DW bits, imaginary part in the lower DW bits.
- threshold  in  2*DW+1  minimum peak power; sampled together with the frame.
- busy  out  1  high while a captured frame is being scanned.
- done  out  1  one-cycle pulse; freq, peak_mag and no_peak are valid from this cycle on.
- freq  out  IDXW  index of the peak bin; 0 when no_peak is set.
- peak_mag  out  2*DW+1  unsigned power of the peak bin.
- no_peak  out  1  set when peak power < threshold.
- overrun  out  1  one-cycle pulse when a frame is dropped.

## Operation
- Three states: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE, fft_valid=1:
  - capture all of fft_d and threshold into an internal buffer;
  - k←0, best_mag←0, best_idx←0;
  - go to SCAN.
- SCAN, one bin per cycle:
  - mag_k = re_k*re_k + im_k*im_k, computed signed then treated as unsigned, width 2*DW+1;
  - update best when mag_k > best_mag (strictly greater), so ties keep the lowest index;
  - bin 0 (DC) is included in the scan;
  - LAST = NBINS-1 for full spectrum, NBINS/2 for half spectrum;
  - after processing k=LAST, go to DONE.
- DONE, lasts one cycle:
  - done=1; freq, peak_mag and no_peak are updated;
  - no_peak = (best_mag < threshold); if no_peak, freq=0, but peak_mag still reports best_mag;
  - return to IDLE, or go straight to a new capture if fft_valid=1 in this cycle.
- Result outputs hold their value until the next DONE or reset.
- fft_valid=1 in SCAN: the frame is dropped, overrun pulses for 1 cycle, and the current scan is unaffected.
- fft_valid=1 in DONE: the frame is accepted (no overrun).
- rst=1 in any state:
  - returns to IDLE and clears all outputs to 0 on the next edge;
  - an in-flight scan is discarded with no done;
  - fft_valid in the same cycle as rst is ignored.
- Width rules:
  - (-2^(DW-1))² must not overflow; full-scale re and im together give 2^(2DW-1), which fits in 2*DW+1 bits;
  - the comparison is unsigned over the full width.

## Timing
- Reset values: busy=0, done=0, freq=0, peak_mag=0, no_peak=0, overrun=0.
- Edge E0 samples fft_valid=1. busy=1 from E0 through the last SCAN cycle.
- N_SCAN = LAST+1 (16 for the default parameters, 9 for NBINS=16 with HALF_SPECTRUM=1).
- done is high in the cycle after edge E0+N_SCAN, i.e. a latency of N_SCAN+1 edges from capture (17 by default).
- busy=0 during the done cycle. Maximum sustained rate is one frame per N_SCAN+1 cycles.
- overrun is registered: it is high in the cycle after the offending fft_valid edge.

## Test plan
- Defaults. Bin 1 = (0x0400, 0) and bin 15 = (0x0400, 0), all others 0, threshold=0 → done 17 cycles after capture; freq=1 (tie resolved to lowest index); peak_mag=0x100000; no_peak=0.
- HALF_SPECTRUM=1, NBINS=16. Bin 15 = (0x7FFF, 0), bin 3 = (0, 0x0100) → freq=3; peak_mag=0x10000; done at 10 cycles.
- Threshold=0x20000, all bins (0x0100, 0x0100) (power 0x20000 each) → freq=0, no_peak=0 (equal power passes). Repeat with threshold=0x20001 → no_peak=1, freq=0, peak_mag=0x20000.
- Sign and width. Bin 7 = (0x8000, 0x8000), others 0x7FFF/0 → freq=7; peak_mag=0x80000000 exactly (no overflow).
- Back-to-back frames:
  - second fft_valid 5 cycles after the first → overrun pulse, first result unchanged, no second done;
  - fft_valid exactly in the done cycle → accepted, second done 17 cycles later.
- Reset mid-scan. rst asserted 8 cycles into SCAN → all outputs 0 on the next edge, no done; a fresh frame afterwards completes normally.
